// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bus bundle: master requests in, grant/ownership out.
// The slave modport is the arbiter's view; the master modport is the requester side.
interface ahb_arbiter_if #(
  parameter int NUM_MST = 4
);
  logic [NUM_MST-1:0] HBUSREQ;
  logic [NUM_MST-1:0] HLOCK;
  logic [1:0]         HTRANS;
  logic [2:0]         HBURST;
  logic               HREADY;
  logic [1:0]         HRESP;
  logic [15:0]        HSPLIT;
  logic [NUM_MST-1:0] HGRANT;
  logic [3:0]         HMASTER;
  logic               HMASTERLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTERLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
    input  HGRANT, HMASTER, HMASTERLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with lock, fixed-burst protection and SPLIT masking.
// HGRANT moves one cycle after an arbitration point; HMASTER follows on the next HREADY edge; stalls hold everything.
module ahb_arbiter #(
  parameter int NUM_MST     = 4,
  parameter int DEFAULT_MST = 0
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_arbiter_if.slave bus
);

  localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam logic [IW-1:0]      DEF_IDX   = IW'(DEFAULT_MST);
  localparam logic [NUM_MST-1:0] DEF_GRANT = {{(NUM_MST-1){1'b0}}, 1'b1} << DEFAULT_MST;

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_MST-1:0] split_q, split_d;
  logic [3:0]         hmaster_q, hmaster_d;
  logic               hmlock_q, hmlock_d;
  logic               lock_hold_q, lock_hold_d;

  logic [NUM_MST-1:0] req;
  logic [IW-1:0]      winner;
  logic               found;
  logic               fixed_nonseq;
  logic               burst_done;
  logic               term_first;
  logic               term_second;
  logic               owner_lock;
  logic               arb;
  logic               unused_hsplit;

  assign unused_hsplit = &{1'b0, bus.HSPLIT};

  always_comb begin
    fixed_nonseq = (bus.HTRANS == TR_NONSEQ) && (bus.HBURST > 3'd1);
    term_first   = (bus.HRESP != RESP_OKAY) && !bus.HREADY;
    term_second  = (bus.HRESP != RESP_OKAY) && bus.HREADY;
    owner_lock   = bus.HLOCK[rr_q];
    burst_done   = ((cnt_q == 4'd0) && !fixed_nonseq) ||
                   ((cnt_q == 4'd1) && (bus.HTRANS == TR_SEQ));
    arb          = bus.HREADY && !owner_lock && !lock_hold_q && (burst_done || term_second);
    req          = bus.HBUSREQ & ~split_q;
  end

  // Round-robin search: indices above the last owner first, then wrap around.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!found && req[i] && (i > int'(rr_q))) begin
        winner = IW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MST; i++) begin
      if (!found && req[i] && (i <= int'(rr_q))) begin
        winner = IW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (term_first) begin
      cnt_d = 4'd0;
    end else if (bus.HREADY) begin
      if (bus.HTRANS == TR_NONSEQ) begin
        case (bus.HBURST)
          3'd2, 3'd3: cnt_d = 4'd3;
          3'd4, 3'd5: cnt_d = 4'd7;
          3'd6, 3'd7: cnt_d = 4'd15;
          default:    cnt_d = 4'd0;
        endcase
      end else if ((bus.HTRANS == TR_SEQ) && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // The cycle after HLOCK falls is still owned by the locking master.
  always_comb begin
    lock_hold_d = lock_hold_q;
    if (owner_lock) begin
      lock_hold_d = 1'b1;
    end else if (bus.HREADY) begin
      lock_hold_d = 1'b0;
    end
  end

  always_comb begin
    split_d = split_q;
    if (term_first && (bus.HRESP == RESP_SPLIT)) begin
      for (int i = 0; i < NUM_MST; i++) begin
        if ((i != DEFAULT_MST) && (hmaster_q == 4'(i))) begin
          split_d[i] = 1'b1;
        end
      end
    end
    split_d = split_d & ~bus.HSPLIT[NUM_MST-1:0];
  end

  always_comb begin
    grant_d   = grant_q;
    rr_d      = rr_q;
    hmaster_d = hmaster_q;
    hmlock_d  = hmlock_q;
    if (arb) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      rr_d            = winner;
    end
    if (bus.HREADY) begin
      hmaster_d = 4'(rr_q);
      hmlock_d  = owner_lock;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q     <= DEF_GRANT;
      rr_q        <= DEF_IDX;
      cnt_q       <= 4'd0;
      split_q     <= '0;
      hmaster_q   <= 4'(DEFAULT_MST);
      hmlock_q    <= 1'b0;
      lock_hold_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      split_q     <= split_d;
      hmaster_q   <= hmaster_d;
      hmlock_q    <= hmlock_d;
      lock_hold_q <= lock_hold_d;
    end
  end

  assign bus.HGRANT      = grant_q;
  assign bus.HMASTER     = hmaster_q;
  assign bus.HMASTERLOCK = hmlock_q;

endmodule
